// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the 640x480 @ 60 Hz raster timing generator.
//   coord_t     : 10-bit raster coordinate (covers totals up to 1023)
//   phase_t     : per-axis timing phase (ACTIVE -> FRONT -> SYNC -> BACK)
//   *_480P      : default phase lengths for the 480p mode
//   sync_level  : maps "sync phase active" to the pin level for a polarity
// -----------------------------------------------------------------------------
package vga_pkg;

   typedef logic [9:0] coord_t;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_t;

   localparam int H_ACTIVE_480P = 640;
   localparam int H_FP_480P     = 16;
   localparam int H_SYNC_480P   = 96;
   localparam int H_BP_480P     = 48;

   localparam int V_ACTIVE_480P = 480;
   localparam int V_FP_480P     = 10;
   localparam int V_SYNC_480P   = 2;
   localparam int V_BP_480P     = 33;

   // Largest total a coord_t can count up to.
   localparam int COORD_MAX = 1023;

   // Pin level for a sync output: with negative polarity the pulse is a low.
   function automatic logic sync_level(input logic active, input logic neg);
      return active ^ neg;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a running position plus a four-phase FSM
// (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE) with a phase-local counter.
// Position and phase describe the coordinate that will be presented next;
// the top module registers them into the visible outputs.
//   clk_pix    in  pixel clock
//   rst        in  synchronous active-high reset
//   step       in  advance by one position this cycle
//   len_active in  length of the active phase
//   len_front  in  length of the front porch
//   len_sync   in  length of the sync pulse
//   len_back   in  length of the back porch
//   pos        out running position, 0..total-1
//   phase      out current phase (phase_t encoding)
//   wrap       out high on the step that takes pos from total-1 back to 0
//   sync_act   out high while in the sync phase
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
(
   input  logic       clk_pix,
   input  logic       rst,
   input  logic       step,
   input  logic [9:0] len_active,
   input  logic [9:0] len_front,
   input  logic [9:0] len_sync,
   input  logic [9:0] len_back,
   output logic [9:0] pos,
   output logic [1:0] phase,
   output logic       wrap,
   output logic       sync_act
);

   phase_t phase_q;
   coord_t phase_cnt;
   coord_t phase_len;
   logic   phase_last;
   logic   at_end;

   // NOTE: every signal assigned in always_comb gets a value on every path
   // (here via the full enum case plus a default first); otherwise a latch
   // is inferred.
   always_comb begin
      phase_len = len_active;
      case (phase_q)
         ACTIVE: phase_len = len_active;
         FRONT:  phase_len = len_front;
         SYNC:   phase_len = len_sync;
         BACK:   phase_len = len_back;
      endcase
   end

   assign phase_last = (phase_cnt == phase_len - 10'd1);
   // Last position of the whole axis: final cycle of the back porch.
   assign at_end     = (phase_q == BACK) && phase_last;

   assign wrap     = step && at_end;
   assign sync_act = (phase_q == SYNC);
   assign phase    = phase_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         phase_q   <= ACTIVE;
         phase_cnt <= '0;
         pos       <= '0;
      end else if (step) begin
         if (phase_last) begin
            phase_cnt <= '0;
            case (phase_q)
               ACTIVE: phase_q <= FRONT;
               FRONT:  phase_q <= SYNC;
               SYNC:   phase_q <= BACK;
               BACK:   phase_q <= ACTIVE;
            endcase
         end else begin
            phase_cnt <= phase_cnt + 10'd1;
         end
         pos <= at_end ? '0 : pos + 10'd1;
      end
   end

endmodule

// File: rtl/vga_timing_480p.sv
// -----------------------------------------------------------------------------
// vga_timing_480p
// Raster timing generator, 640x480 @ 60 Hz by default (800 x 525 totals).
// Two vga_axis_counter instances track the next coordinate; a single output
// register stage presents that coordinate together with its sync, data-enable
// and strobe flags, so all outputs are registered and mutually aligned.
//   clk_pix in  25 MHz pixel clock
//   rst     in  synchronous active-high reset
//   en      in  advance enable (pixel-clock lock flag); 0 freezes everything
//   sx, sy  out presented coordinate
//   hsync   out horizontal sync, polarity per SYNC_NEG
//   vsync   out vertical sync, polarity per SYNC_NEG
//   de      out high inside the visible area
//   line    out one-cycle strobe on the first cycle sx = 0 is presented
//   frame   out one-cycle strobe on the first cycle (0,0) is presented
// -----------------------------------------------------------------------------
module vga_timing_480p
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_480P,
   parameter int H_FP     = H_FP_480P,
   parameter int H_SYNC   = H_SYNC_480P,
   parameter int H_BP     = H_BP_480P,
   parameter int V_ACTIVE = V_ACTIVE_480P,
   parameter int V_FP     = V_FP_480P,
   parameter int V_SYNC   = V_SYNC_480P,
   parameter int V_BP     = V_BP_480P,
   parameter bit SYNC_NEG = 1'b1
)
(
   input  logic       clk_pix,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] sx,
   output logic [9:0] sy,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       line,
   output logic       frame
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > COORD_MAX) begin : g_h_total_check
      $error("vga_timing_480p: H_TOTAL %0d does not fit in 10 bits", H_TOTAL);
   end
   if (V_TOTAL > COORD_MAX) begin : g_v_total_check
      $error("vga_timing_480p: V_TOTAL %0d does not fit in 10 bits", V_TOTAL);
   end

   logic [9:0] h_pos;
   logic [9:0] v_pos;
   logic [1:0] h_phase;
   logic [1:0] v_phase;
   logic       h_wrap;
   logic       h_sync_act;
   logic       v_sync_act;
   logic       unused_v_wrap;

   vga_axis_counter u_h_axis (
      .clk_pix    (clk_pix),
      .rst        (rst),
      .step       (en),
      .len_active (10'(H_ACTIVE)),
      .len_front  (10'(H_FP)),
      .len_sync   (10'(H_SYNC)),
      .len_back   (10'(H_BP)),
      .pos        (h_pos),
      .phase      (h_phase),
      .wrap       (h_wrap),
      .sync_act   (h_sync_act)
   );

   // The vertical axis moves one line each time the horizontal axis wraps.
   vga_axis_counter u_v_axis (
      .clk_pix    (clk_pix),
      .rst        (rst),
      .step       (h_wrap),
      .len_active (10'(V_ACTIVE)),
      .len_front  (10'(V_FP)),
      .len_sync   (10'(V_SYNC)),
      .len_back   (10'(V_BP)),
      .pos        (v_pos),
      .phase      (v_phase),
      .wrap       (unused_v_wrap),
      .sync_act   (v_sync_act)
   );

   // Output stage: load the counters' coordinate on each enabled edge. The
   // counters start at 0 after reset, so the first enabled edge presents
   // (0,0) with both strobes. While frozen, the strobes drop so each fires
   // only once per presented coordinate.
   always_ff @(posedge clk_pix) begin
      if (rst) begin
         sx    <= '0;
         sy    <= '0;
         de    <= 1'b0;
         line  <= 1'b0;
         frame <= 1'b0;
         hsync <= sync_level(1'b0, SYNC_NEG);
         vsync <= sync_level(1'b0, SYNC_NEG);
      end else if (en) begin
         sx    <= h_pos;
         sy    <= v_pos;
         de    <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
         line  <= (h_pos == '0);
         frame <= (h_pos == '0) && (v_pos == '0);
         hsync <= sync_level(h_sync_act, SYNC_NEG);
         vsync <= sync_level(v_sync_act, SYNC_NEG);
      end else begin
         line  <= 1'b0;
         frame <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_480p.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_480p
// Drives three instances from one clock/reset/enable:
//   dut   : default 480p timing, negative sync
//   dut_p : 480p timing with SYNC_NEG=0
//   dut_s : shrunken raster (20 x 13) so whole frames fit in a short run
// -----------------------------------------------------------------------------
module tb_vga_timing_480p;

   logic clk_pix = 1'b0;
   logic rst;
   logic en;

   always #20 clk_pix = ~clk_pix;

   logic [9:0] sx_d, sy_d, sx_p, sy_p, sx_s, sy_s;
   logic hsync_d, vsync_d, de_d, line_d, frame_d;
   logic hsync_p, vsync_p, de_p, line_p, frame_p;
   logic hsync_s, vsync_s, de_s, line_s, frame_s;

   vga_timing_480p dut (
      .clk_pix (clk_pix), .rst (rst), .en (en),
      .sx (sx_d), .sy (sy_d), .hsync (hsync_d), .vsync (vsync_d),
      .de (de_d), .line (line_d), .frame (frame_d)
   );

   vga_timing_480p #(.SYNC_NEG(1'b0)) dut_p (
      .clk_pix (clk_pix), .rst (rst), .en (en),
      .sx (sx_p), .sy (sy_p), .hsync (hsync_p), .vsync (vsync_p),
      .de (de_p), .line (line_p), .frame (frame_p)
   );

   // 10+2+3+5 = 20 pixels per line, 6+2+2+3 = 13 lines, 260 cycles per frame.
   vga_timing_480p #(
      .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
      .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut_s (
      .clk_pix (clk_pix), .rst (rst), .en (en),
      .sx (sx_s), .sy (sy_s), .hsync (hsync_s), .vsync (vsync_s),
      .de (de_s), .line (line_s), .frame (frame_s)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk_pix);
      @(negedge clk_pix);
   endtask

   // Statistics gathered while free-running.
   int n = 0;
   int de_fall_sx = -1, hs_cnt = 0, hs_first = -1, hs_last = -1, de_bad = 0;
   int pos_hs_cnt = 0, pos_hs_first = -1, pos_diff = 0;
   int line_n[$];
   int sy2 = -1, frame2 = -1;
   int sm_frame_n[$];
   int sm_de_cnt = 0, sm_vs_cnt = 0, sm_vs_bad = 0, sm_hs_bad = 0, sm_de_bad = 0;
   int sm_step_bad = 0, sm_frame_wraps = 0;
   int sm_prev_sx = 0, sm_prev_sy = 0;

   task automatic collect();
      if (sy_d == 10'd0) begin
         if (!de_d && de_fall_sx < 0) de_fall_sx = int'(sx_d);
         if (!hsync_d) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(sx_d);
            hs_last = int'(sx_d);
         end
         if (hsync_p) begin
            pos_hs_cnt++;
            if (pos_hs_first < 0) pos_hs_first = int'(sx_p);
         end
      end
      if (de_d != (sx_d < 10'd640 && sy_d < 10'd480)) de_bad++;
      if (line_d) begin
         if (line_n.size() == 1) begin
            sy2    = int'(sy_d);
            frame2 = int'(frame_d);
         end
         line_n.push_back(n);
      end
      if (sx_p !== sx_d || sy_p !== sy_d || de_p !== de_d || line_p !== line_d ||
          frame_p !== frame_d || hsync_p !== ~hsync_d || vsync_p !== ~vsync_d)
         pos_diff++;

      if (frame_s) sm_frame_n.push_back(n);
      if (n < 260) begin
         if (de_s)     sm_de_cnt++;
         if (!vsync_s) sm_vs_cnt++;
      end
      if ((!vsync_s) != (sy_s == 10'd8 || sy_s == 10'd9)) sm_vs_bad++;
      if ((!hsync_s) != (sx_s >= 10'd12 && sx_s <= 10'd14)) sm_hs_bad++;
      if (de_s != (sx_s < 10'd10 && sy_s < 10'd6)) sm_de_bad++;
      if (n > 0) begin
         if (sm_prev_sx == 19 && sm_prev_sy == 12) begin
            sm_frame_wraps++;
            if (!(sx_s == 10'd0 && sy_s == 10'd0 && frame_s && line_s)) sm_step_bad++;
         end else if (sm_prev_sx == 19) begin
            if (!(sx_s == 10'd0 && int'(sy_s) == sm_prev_sy + 1 && line_s && !frame_s))
               sm_step_bad++;
         end else if (!(int'(sx_s) == sm_prev_sx + 1 && int'(sy_s) == sm_prev_sy &&
                        !line_s && !frame_s)) begin
            sm_step_bad++;
         end
      end
      sm_prev_sx = int'(sx_s);
      sm_prev_sy = int'(sy_s);
   endtask

   // Packed view {sx, sy, de, line, frame, hsync, vsync} of the default DUT.
   function automatic logic [31:0] snap_d();
      return {7'd0, sx_d, sy_d, de_d, line_d, frame_d, hsync_d, vsync_d};
   endfunction

   initial begin
      #10_000_000;
      $display("FAIL watchdog expired got=0 exp=1");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] hold_sx;
      logic       hold_hs, hold_de, hold_vs;
      int         hold_bad, strobe_bad, found;

      rst = 1'b1;
      en  = 1'b1;
      repeat (3) tick();

      // Reset state.
      check("reset_d", snap_d(), {7'd0, 10'd0, 10'd0, 5'b00011});
      check("reset_p_sync", {30'd0, hsync_p, vsync_p}, 32'd0);
      check("reset_s_strobes", {29'd0, de_s, line_s, frame_s}, 32'd0);

      // First enabled edge after release presents (0,0) with both strobes.
      rst = 1'b0;
      tick();
      check("first_cycle", snap_d(), {7'd0, 10'd0, 10'd0, 5'b11111});
      collect();
      for (int i = 1; i <= 1100; i++) begin
         tick();
         n++;
         collect();
      end

      check("de_fall_sx", de_fall_sx, 640);
      check("de_region_errs", de_bad, 0);
      check("hsync_low_cnt", hs_cnt, 96);
      check("hsync_first_sx", hs_first, 656);
      check("hsync_last_sx", hs_last, 751);
      check("line_strobe_cnt", line_n.size(), 2);
      check("line_period", (line_n.size() >= 2) ? line_n[1] - line_n[0] : -1, 800);
      check("line2_sy", sy2, 1);
      check("line2_frame", frame2, 0);
      check("pos_hsync_cnt", pos_hs_cnt, 96);
      check("pos_hsync_first", pos_hs_first, 656);
      check("pos_other_diff", pos_diff, 0);

      check("sm_frame_cnt", sm_frame_n.size(), 5);
      check("sm_frame_period", (sm_frame_n.size() >= 2) ? sm_frame_n[1] - sm_frame_n[0] : -1, 260);
      check("sm_frame_last", (sm_frame_n.size() == 5) ? sm_frame_n[4] : -1, 1040);
      check("sm_frame_wraps", sm_frame_wraps, 4);
      check("sm_step_errs", sm_step_bad, 0);
      check("sm_de_cnt", sm_de_cnt, 60);
      check("sm_vsync_cnt", sm_vs_cnt, 40);
      check("sm_vsync_errs", sm_vs_bad, 0);
      check("sm_hsync_errs", sm_hs_bad, 0);
      check("sm_de_errs", sm_de_bad, 0);

      // Freeze for 37 cycles at sx=700 on line 1 (inside the sync pulse).
      repeat (400) begin
         tick();
         n++;
      end
      check("freeze_at", {sx_d, sy_d}, {10'd700, 10'd1});
      check("freeze_hsync", hsync_d, 1'b0);
      hold_sx = sx_d;
      hold_hs = hsync_d;
      hold_de = de_d;
      hold_vs = vsync_d;
      hold_bad   = 0;
      strobe_bad = 0;
      en = 1'b0;
      for (int i = 0; i < 37; i++) begin
         tick();
         if (sx_d !== hold_sx || sy_d !== 10'd1 || hsync_d !== hold_hs ||
             de_d !== hold_de || vsync_d !== hold_vs) hold_bad++;
         if (line_d || frame_d || line_s || frame_s) strobe_bad++;
      end
      check("freeze_hold_errs", hold_bad, 0);
      check("freeze_strobe_errs", strobe_bad, 0);
      en = 1'b1;
      tick();
      n++;
      check("resume_sx", sx_d, 10'd701);

      // Line length in enabled cycles is unchanged by the freeze.
      found = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         n++;
         if (line_d) begin
            found = 1;
            break;
         end
      end
      check("line_after_freeze_found", found, 1);
      check("line_len_enabled", n - 800, 800);
      check("line_after_freeze_pos", {sx_d, sy_d}, {10'd0, 10'd2});

      // Reset in mid-frame.
      repeat (300) tick();
      check("pre_rst_pos", {sx_d, sy_d}, {10'd300, 10'd2});
      rst = 1'b1;
      tick();
      check("rst_mid", snap_d(), {7'd0, 10'd0, 10'd0, 5'b00011});
      check("rst_mid_p_sync", {30'd0, hsync_p, vsync_p}, 32'd0);
      check("rst_mid_s", {sx_s, sy_s, de_s}, {10'd0, 10'd0, 1'b0});
      tick();
      check("rst_with_en", snap_d(), {7'd0, 10'd0, 10'd0, 5'b00011});
      rst = 1'b0;
      tick();
      check("restart", snap_d(), {7'd0, 10'd0, 10'd0, 5'b11111});
      repeat (4) tick();
      check("restart_adv", snap_d(), {7'd0, 10'd4, 10'd0, 5'b10011});

      // Reset with en low still resets; release with en low stays put.
      rst = 1'b1;
      en  = 1'b0;
      tick();
      check("rst_no_en", snap_d(), {7'd0, 10'd0, 10'd0, 5'b00011});
      rst = 1'b0;
      tick();
      check("released_frozen", snap_d(), {7'd0, 10'd0, 10'd0, 5'b00011});
      en = 1'b1;
      tick();
      check("enable_after_rst", snap_d(), {7'd0, 10'd0, 10'd0, 5'b11111});
      tick();
      check("second_pixel", snap_d(), {7'd0, 10'd1, 10'd0, 5'b10011});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
